inst_fetch: RTL and testbench

Instruction fetch stage of the RV32I core: holds the PC, issues word reads to instruction memory over a req/ack handshake, and presents each fetched 32-bit instruction word with its PC to the decode stage (register read and immediate generation) through a one-entry valid/ready output buffer. It accepts a PC redirect from execute (taken branch, jal, jalr) and discards any wrong-path fetch.

---
 rtl/inst_fetch.sv | 125 ++++++++++++
 tb/tb_inst_fetch.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// inst_fetch - RV32I instruction fetch stage.
//
// Holds the PC, issues one word read at a time to instruction memory over a
// req/ack handshake, and hands each fetched word plus its PC to decode through
// a one-entry valid/ready buffer. A redirect from execute retargets the PC;
// a read already in flight when the redirect lands is allowed to finish and
// its data is thrown away (DROP), so no wrong-path word is ever presented.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   imem_req/addr           read request and word address (held until ack)
//   imem_ack/rdata          read completion and returned word
//   redir_valid/pc          one-cycle PC redirect, target low bits ignored
//   inst_valid/inst/inst_pc output buffer to decode
//   inst_ready              decode consumes the buffer this cycle
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT_OUT, DROP} state_t;

  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
    logic [31:0] word;
  } obuf_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] req_addr, req_addr_n;
  obuf_t       ob, ob_n;
  logic [31:0] tgt;

  // Word-aligned redirect target; masking keeps every input bit in use.
  assign tgt = redir_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      ob       <= '0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      req_addr <= req_addr_n;
      ob       <= ob_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    req_addr_n = req_addr;
    ob_n       = ob;
    case (state)
      IDLE: begin
        state_n = FETCH;
        if (redir_valid) begin
          pc_n       = tgt;
          req_addr_n = tgt;
        end else begin
          req_addr_n = pc;
        end
      end
      FETCH: begin
        if (redir_valid) begin
          pc_n = tgt;
          // Acked word is wrong-path: drop it and issue the target at once.
          // Unacked: the old read must still complete before the target goes out.
          if (imem_ack) req_addr_n = tgt;
          else          state_n    = DROP;
        end else if (imem_ack) begin
          ob_n.vld  = 1'b1;
          ob_n.word = imem_rdata;
          ob_n.pc   = req_addr;
          pc_n      = req_addr + 32'd4;
          state_n   = WAIT_OUT;
        end
      end
      WAIT_OUT: begin
        // Redirect beats a same-cycle consume: the buffered word is flushed.
        if (redir_valid) begin
          ob_n.vld   = 1'b0;
          pc_n       = tgt;
          req_addr_n = tgt;
          state_n    = FETCH;
        end else if (ob.vld && inst_ready) begin
          ob_n.vld   = 1'b0;
          req_addr_n = pc;
          state_n    = FETCH;
        end
      end
      DROP: begin
        if (redir_valid) pc_n = tgt;
        if (imem_ack) begin
          req_addr_n = redir_valid ? tgt : pc;
          state_n    = FETCH;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Request decoded from registered state only.
  assign imem_req   = (state == FETCH) || (state == DROP);
  assign imem_addr  = req_addr;
  assign inst_valid = ob.vld;
  assign inst       = ob.word;
  assign inst_pc    = ob.pc;

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch - directed bench for inst_fetch. A behavioural memory acks
// after a programmable number of wait cycles; all checks sample on the
// falling edge and go through chk().
module tb_inst_fetch;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  int total = 0;
  int bad   = 0;
  int lat   = 0;
  int wcnt  = 0;
  int cnt4  = 0;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(32'h0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .redir_valid(redir_valid),
    .redir_pc   (redir_pc),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready)
  );

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a == 32'h0) ? 32'hf801_0113 : (a ^ 32'h0bad_c0de);
  endfunction

  // Memory: ack once the request has waited 'lat' cycles.
  assign imem_ack   = imem_req && (wcnt >= lat);
  assign imem_rdata = imem_ack ? memw(imem_addr) : 32'hdead_beef;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   wcnt <= 0;
    else if (imem_ack)            wcnt <= 0;
    else if (imem_req)            wcnt <= wcnt + 1;
  end

  always @(posedge clk)
    if (imem_req && imem_ack && imem_addr == 32'h4) cnt4 <= cnt4 + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Release reset on a falling edge; returns at the first cycle in FETCH.
  task automatic rel();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic redir(input logic [31:0] t);
    redir_valid = 1'b1;
    redir_pc    = t;
    step();
    redir_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (inst_valid) break;
      step();
    end
    chk(tag, {31'b0, inst_valid}, 32'h1);
  endtask

  int c0;

  initial begin
    rst_n = 1'b0; inst_ready = 1'b1; redir_valid = 1'b0; redir_pc = '0;
    #2;
    chk("rst_req",   {31'b0, imem_req},   32'h0);
    chk("rst_addr",  imem_addr,           32'h0);
    chk("rst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_inst",  inst,                32'h0);
    chk("rst_pc",    inst_pc,             32'h0);

    // Zero-wait streaming, inst_ready high.
    rel();
    for (int k = 0; k < 3; k++) begin
      chk("seq_req",   {31'b0, imem_req},   32'h1);
      chk("seq_addr",  imem_addr,           32'(4*k));
      chk("seq_nv",    {31'b0, inst_valid}, 32'h0);
      step();
      chk("seq_valid", {31'b0, inst_valid}, 32'h1);
      chk("seq_ipc",   inst_pc,             32'(4*k));
      chk("seq_inst",  inst,                memw(32'(4*k)));
      chk("seq_noreq", {31'b0, imem_req},   32'h0);
      step();
    end

    // Backpressure.
    rst_n = 1'b0; inst_ready = 1'b0;
    step();
    rel();
    c0 = cnt4;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'b0, inst_valid}, 32'h1);
      chk("bp_inst",  inst,                32'hf801_0113);
      chk("bp_ipc",   inst_pc,             32'h0);
      chk("bp_req",   {31'b0, imem_req},   32'h0);
      step();
    end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("bp_addr4", imem_addr, 32'h4);
    step();
    chk("bp_ipc4", inst_pc, 32'h4);
    for (int i = 0; i < 3; i++) begin
      chk("bp_req2", {31'b0, imem_req}, 32'h0);
      step();
    end
    chk("bp_cnt4", 32'(cnt4 - c0), 32'h1);

    // Redirect in WAIT_OUT with a simultaneous consume.
    inst_ready = 1'b1;
    redir(32'h80);
    inst_ready = 1'b0;
    chk("wr_flush", {31'b0, inst_valid}, 32'h0);
    chk("wr_addr",  imem_addr,           32'h80);
    chk("wr_req",   {31'b0, imem_req},   32'h1);
    step();
    chk("wr_ipc",   inst_pc,             32'h80);
    chk("wr_inst",  inst,                memw(32'h80));

    // Redirect while a read is outstanding (latency 3).
    lat = 3;
    redir(32'h10);
    chk("dr_addr0", imem_addr, 32'h10);
    step();
    chk("dr_addr1", imem_addr, 32'h10);
    redir(32'h100);
    chk("dr_addr2", imem_addr, 32'h10);
    chk("dr_nv2",   {31'b0, inst_valid}, 32'h0);
    step();
    chk("dr_addr3", imem_addr, 32'h10);
    chk("dr_ack3",  {31'b0, imem_ack},   32'h1);
    step();
    chk("dr_next",  imem_addr, 32'h100);
    chk("dr_nv4",   {31'b0, inst_valid}, 32'h0);
    wait_valid("dr_timeout");
    chk("dr_ipc",   inst_pc, 32'h100);
    chk("dr_inst",  inst,    memw(32'h100));

    // Two redirects during DROP, second one misaligned.
    redir(32'h20);
    chk("dd_addr0", imem_addr, 32'h20);
    redir(32'h200);
    redir(32'h303);
    chk("dd_hold",  imem_addr, 32'h20);
    step();
    chk("dd_ack",   {31'b0, imem_ack}, 32'h1);
    step();
    chk("dd_next",  imem_addr, 32'h300);
    chk("dd_req",   {31'b0, imem_req}, 32'h1);
    wait_valid("dd_timeout");
    chk("dd_ipc",   inst_pc, 32'h300);

    // PC wrap.
    lat = 0;
    redir(32'hFFFF_FFFC);
    chk("wp_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("wp_ipc",  inst_pc,   32'hFFFF_FFFC);
    lat = 5; inst_ready = 1'b1;
    step();
    chk("wp_next", imem_addr, 32'h0);
    chk("wp_req",  {31'b0, imem_req}, 32'h1);
    chk("wp_nack", {31'b0, imem_ack}, 32'h0);

    // Asynchronous reset mid-request.
    #1 rst_n = 1'b0;
    #1;
    chk("ar_req",   {31'b0, imem_req},   32'h0);
    chk("ar_valid", {31'b0, inst_valid}, 32'h0);
    chk("ar_addr",  imem_addr,           32'h0);
    lat = 0;
    rel();
    chk("ar_req2",  {31'b0, imem_req}, 32'h1);
    chk("ar_addr2", imem_addr,         32'h0);
    step();
    chk("ar_ipc",   inst_pc, 32'h0);
    chk("ar_inst",  inst,    32'hf801_0113);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
